uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-wide UART transmitter.
// Grants are held for a packet, capped at MAX_BURST bytes, and revoked on owner stall.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned STALL_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [7:0] r0_data,
  input  logic       r0_valid,
  input  logic       r0_last,
  output logic       r0_ready,
  input  logic [7:0] r1_data,
  input  logic       r1_valid,
  input  logic       r1_last,
  output logic       r1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_idle,
  output logic [1:0] grant,
  output logic       busy,
  output logic       abort
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
  localparam logic [15:0] StallMax = 16'(STALL_CYCLES);

  typedef enum logic [1:0] {StIdle, StServe, StDrain} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [1:0]          grant_q, grant_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [15:0]         stall_q, stall_d;
  logic                drain_wait_q, drain_wait_d;
  logic                armed_q, armed_d;

  logic [7:0]          own_data;
  logic                own_valid;
  logic                own_last;
  logic [BurstW-1:0]   burst_inc;

  assign own_data  = owner_q ? r1_data  : r0_data;
  assign own_valid = owner_q ? r1_valid : r0_valid;
  assign own_last  = owner_q ? r1_last  : r0_last;
  assign burst_inc = burst_q + BurstW'(1);

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    grant_d      = grant_q;
    burst_d      = burst_q;
    stall_d      = stall_q;
    drain_wait_d = drain_wait_q;
    // Arbitration is held off for the first edge after reset release.
    armed_d      = 1'b1;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    abort        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (armed_q && (r0_valid || r1_valid)) begin
          // last_q names the requester served most recently; the other wins a tie.
          owner_d = (r0_valid && r1_valid) ? ~last_q : r1_valid;
          grant_d = owner_d ? 2'b10 : 2'b01;
          burst_d = '0;
          stall_d = '0;
          state_d = StServe;
        end
      end
      StServe: begin
        if (stall_q == StallMax) begin
          abort   = 1'b1;
          grant_d = 2'b00;
          last_d  = owner_q;
          state_d = StIdle;
        end else begin
          tx_data  = own_data;
          tx_valid = own_valid;
          r0_ready = !owner_q && tx_ready;
          r1_ready = owner_q && tx_ready;
          if (own_valid && tx_ready) begin
            burst_d = burst_inc;
            stall_d = '0;
            if (own_last || (burst_inc == BurstMax)) begin
              drain_wait_d = 1'b1;
              state_d      = StDrain;
            end
          end else if (!own_valid) begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      StDrain: begin
        // tx_idle is ignored on the first DRAIN cycle: the transmitter drops
        // idle one cycle after accepting the final byte.
        drain_wait_d = 1'b0;
        if (!drain_wait_q && tx_idle) begin
          grant_d = 2'b00;
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      grant_q      <= 2'b00;
      burst_q      <= '0;
      stall_q      <= '0;
      drain_wait_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      burst_q      <= burst_d;
      stall_q      <= stall_d;
      drain_wait_q <= drain_wait_d;
      armed_q      <= armed_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with MAX_BURST=4, STALL_CYCLES=8.
module tb_uart_tx_arbiter;

  logic       clock = 1'b0;
  logic       clear_n;
  logic [7:0] r0_data, r1_data, tx_data;
  logic       r0_valid, r0_last, r0_ready;
  logic       r1_valid, r1_last, r1_ready;
  logic       tx_valid, tx_ready, tx_idle;
  logic [1:0] grant;
  logic       busy, abort;

  int total = 0;
  int bad   = 0;

  logic [7:0] pkt0 [0:7];
  logic [7:0] pkt1 [0:7];
  int         n0, n1, i0, i1;
  logic       hold0;

  logic [9:0] log_q [$];
  int         aborts = 0;
  logic [9:0] exp3 [0:6];

  always #5 clock = ~clock;

  uart_tx_arbiter #(.MAX_BURST(4), .STALL_CYCLES(8)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .r0_data (r0_data),
    .r0_valid(r0_valid),
    .r0_last (r0_last),
    .r0_ready(r0_ready),
    .r1_data (r1_data),
    .r1_valid(r1_valid),
    .r1_last (r1_last),
    .r1_ready(r1_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_idle (tx_idle),
    .grant   (grant),
    .busy    (busy),
    .abort   (abort)
  );

  always @(negedge clock) begin
    if (tx_valid && tx_ready) log_q.push_back({grant, tx_data});
    if (abort) aborts++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    r0_valid = (i0 < n0) && !hold0;
    r0_data  = (i0 < n0) ? pkt0[i0] : 8'h00;
    r0_last  = (n0 > 0) && (i0 == n0 - 1);
    r1_valid = (i1 < n1);
    r1_data  = (i1 < n1) ? pkt1[i1] : 8'h00;
    r1_last  = (n1 > 0) && (i1 == n1 - 1);
  endtask

  task automatic step();
    logic f0, f1;
    f0 = r0_valid && r0_ready;
    f1 = r1_valid && r1_ready;
    @(posedge clock);
    #1;
    if (f0) i0++;
    if (f1) i1++;
    drive();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_n = 1'b0;
    n0 = 0; n1 = 0; i0 = 0; i1 = 0; hold0 = 1'b0;
    tx_ready = 1'b0; tx_idle = 1'b1;
    drive();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_abort", abort, 1'b0);
    step();
    step();
    clear_n = 1'b1;

    // Single packet from r0
    pkt0[0] = 8'h41; pkt0[1] = 8'h42; pkt0[2] = 8'h43;
    n0 = 3; i0 = 0; tx_ready = 1'b1;
    drive();
    #1;
    chk("idle_no_fwd", tx_valid, 1'b0);
    chk("idle_no_ready", r0_ready, 1'b0);
    step();
    chk("first_edge_no_grant", grant, 2'b00);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1'b1);
    chk("t1_valid", tx_valid, 1'b1);
    chk("t1_d0", tx_data, 8'h41);
    chk("t1_ready", r0_ready, 1'b1);
    step();
    chk("t1_d1", tx_data, 8'h42);
    step();
    chk("t1_d2", tx_data, 8'h43);
    step();
    chk("t1_drain_valid", tx_valid, 1'b0);
    chk("t1_drain_ready", r0_ready, 1'b0);
    chk("t1_drain_grant", grant, 2'b01);
    chk("t1_drain_busy", busy, 1'b1);
    step();
    chk("t1_drain2_grant", grant, 2'b01);
    step();
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_log_n", log_q.size(), 3);
    chk("t1_log0", log_q[0], {2'b01, 8'h41});
    chk("t1_log1", log_q[1], {2'b01, 8'h42});
    chk("t1_log2", log_q[2], {2'b01, 8'h43});

    // Contention after reset, plus handshake back-pressure
    clear_n = 1'b0;
    #1;
    step();
    clear_n = 1'b1;
    log_q.delete();
    pkt0[0] = 8'h10; n0 = 1; i0 = 0;
    pkt1[0] = 8'h20; n1 = 1; i1 = 0;
    tx_ready = 1'b0;
    drive();
    #1;
    step();
    step();
    chk("t2_grant_r0", grant, 2'b01);
    chk("t2_r1_held", r1_ready, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("t2_hold_data", tx_data, 8'h10);
      chk("t2_hold_valid", tx_valid, 1'b1);
      chk("t2_hold_ready", r0_ready, 1'b0);
      step();
    end
    chk("t2_no_abort", aborts, 0);
    chk("t2_grant_kept", grant, 2'b01);
    tx_ready = 1'b1;
    #1;
    chk("t2_ready_up", r0_ready, 1'b1);
    step();
    chk("t2_drain_r1", r1_ready, 1'b0);
    chk("t2_drain_grant", grant, 2'b01);
    step();
    step();
    chk("t2_idle_grant", grant, 2'b00);
    step();
    chk("t2_grant_r1", grant, 2'b10);
    chk("t2_r1_data", tx_data, 8'h20);
    step();
    step();
    step();
    chk("t2_log_n", log_q.size(), 2);
    chk("t2_log0", log_q[0], {2'b01, 8'h10});
    chk("t2_log1", log_q[1], {2'b10, 8'h20});

    // Burst cap: r1 sends 6 bytes while r0 waits
    log_q.delete();
    for (int k = 0; k < 6; k++) pkt1[k] = 8'hA0 + 8'(k);
    n1 = 6; i1 = 0; n0 = 0; i0 = 0;
    drive();
    #1;
    step();
    chk("t3_grant_r1", grant, 2'b10);
    pkt0[0] = 8'h55; n0 = 1; i0 = 0;
    drive();
    #1;
    for (int k = 0; k < 20; k++) step();
    exp3[0] = {2'b10, 8'hA0}; exp3[1] = {2'b10, 8'hA1};
    exp3[2] = {2'b10, 8'hA2}; exp3[3] = {2'b10, 8'hA3};
    exp3[4] = {2'b01, 8'h55}; exp3[5] = {2'b10, 8'hA4};
    exp3[6] = {2'b10, 8'hA5};
    chk("t3_log_n", log_q.size(), 7);
    for (int k = 0; k < 7; k++) chk($sformatf("t3_log%0d", k), log_q[k], exp3[k]);
    chk("t3_end_grant", grant, 2'b00);

    // Stall timeout: r0 drops valid after one byte, r1 pending
    log_q.delete();
    pkt0[0] = 8'h77; pkt0[1] = 8'h78; n0 = 2; i0 = 0;
    n1 = 0; i1 = 0; hold0 = 1'b0;
    drive();
    #1;
    step();
    chk("t4_grant_r0", grant, 2'b01);
    pkt1[0] = 8'h99; n1 = 1; i1 = 0;
    drive();
    #1;
    step();
    hold0 = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_no_abort%0d", k), abort, 1'b0);
      chk("t4_r1_held", r1_ready, 1'b0);
      step();
    end
    chk("t4_abort", abort, 1'b1);
    chk("t4_abort_grant", grant, 2'b01);
    hold0 = 1'b0;
    drive();
    #1;
    step();
    chk("t4_post_grant", grant, 2'b00);
    chk("t4_post_abort", abort, 1'b0);
    chk("t4_post_busy", busy, 1'b0);
    step();
    chk("t4_rr_r1", grant, 2'b10);
    for (int k = 0; k < 12; k++) step();
    chk("t4_log_n", log_q.size(), 3);
    chk("t4_log0", log_q[0], {2'b01, 8'h77});
    chk("t4_log1", log_q[1], {2'b10, 8'h99});
    chk("t4_log2", log_q[2], {2'b01, 8'h78});
    chk("t4_abort_cnt", aborts, 1);

    // Reset mid-SERVE after the second byte
    log_q.delete();
    pkt0[0] = 8'hC1; pkt0[1] = 8'hC2; pkt0[2] = 8'hC3; n0 = 3; i0 = 0;
    n1 = 0; i1 = 0; hold0 = 1'b0;
    drive();
    #1;
    step();
    step();
    step();
    clear_n = 1'b0;
    #1;
    chk("t5_tx_valid", tx_valid, 1'b0);
    chk("t5_grant", grant, 2'b00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ready", r0_ready, 1'b0);
    chk("t5_data", tx_data, 8'h00);
    chk("t5_abort", abort, 1'b0);
    hold0 = 1'b1;
    drive();
    #1;
    step();
    clear_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("t5_quiet_log", log_q.size(), 2);
    chk("t5_quiet_busy", busy, 1'b0);
    hold0 = 1'b0;
    drive();
    #1;
    for (int k = 0; k < 8; k++) step();
    chk("t5_log_n", log_q.size(), 3);
    chk("t5_log0", log_q[0], {2'b01, 8'hC1});
    chk("t5_log1", log_q[1], {2'b01, 8'hC2});
    chk("t5_log2", log_q[2], {2'b01, 8'hC3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
